pwm_capture: RTL and testbench

- Measures an incoming PWM waveform and reports its period and high time, in clk cycles, for each complete cycle.
- Receive-side counterpart of the PWM generator.
- Sits at a top-level input pin and feeds the register file: period and duty readback, loop-back self-test, and external PWM sensing.
- One result per rising-to-rising cycle, qualified by a single-cycle valid pulse.

---
 rtl/pwm_cap_pkg.sv | 23 ++
 rtl/pwm_in_cond.sv | 72 +++++++
 rtl/pwm_capture.sv | 145 ++++++++++++++
 tb/tb_pwm_capture.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_cap_pkg.sv
// Shared types and defaults for the PWM capture block: FSM state encoding,
// default widths, the counter limit source and a state-decoding helper.
package pwm_cap_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } cap_state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILTER_LEN  = 3;

  // All-ones source; users slice it down to their own counter width.
  localparam logic [63:0] CNT_MAX = '1;

  function automatic logic is_measuring(input cap_state_t s);
    return (s == MEAS_HIGH) || (s == MEAS_LOW);
  endfunction

endpackage

// File: rtl/pwm_in_cond.sv
// Input conditioning for pwm_capture: synchroniser, optional glitch filter
// (enabled by defining PWM_CAP_FILTER_EN) and rise/fall edge detection.
module pwm_in_cond
  import pwm_cap_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic s_in,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_param
    $error("pwm_in_cond: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   level;
  logic                   s_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pwm_in};
    end
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [FW-1:0] flt_cnt_reg;
  logic          flt_level_reg;

  // Level flips only once the synchronised input has disagreed with it for
  // FILTER_LEN consecutive samples; both edges see the same delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt_reg   <= '0;
      flt_level_reg <= 1'b0;
    end else if (sync_reg[SYNC_STAGES-1] == flt_level_reg) begin
      flt_cnt_reg <= '0;
    end else if (flt_cnt_reg == FW'(FILTER_LEN - 1)) begin
      flt_cnt_reg   <= '0;
      flt_level_reg <= sync_reg[SYNC_STAGES-1];
    end else begin
      flt_cnt_reg <= flt_cnt_reg + 1'b1;
    end
  end

  assign level = flt_level_reg;
`else
  assign level = sync_reg[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_prev_reg <= 1'b0;
    end else begin
      s_prev_reg <= level;
    end
  end

  assign s_in = level;
  assign rise = level & ~s_prev_reg;
  assign fall = ~level & s_prev_reg;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period (rise to rise) and high time of each complete
// input cycle in clk cycles. Define PWM_CAP_FILTER_EN to add the glitch filter.
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_en,
  input  logic             ovf_clr,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             busy,
  output logic             overflow,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_MAX[CNT_W-1:0];

  logic s_in;
  logic rise;
  logic fall;

  cap_state_t       state_reg,  state_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic [CNT_W-1:0] hi_lat_reg, hi_lat_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] high_reg,   high_next;
  logic             valid_reg,  valid_next;
  logic             ovf_reg,    ovf_next;
  logic             stuck_reg,  stuck_next;
  logic             at_limit;

  pwm_in_cond #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_cond (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (pwm_in),
    .s_in   (s_in),
    .rise   (rise),
    .fall   (fall)
  );

  assign at_limit = (cnt_reg == CNT_LIMIT);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hi_lat_next = hi_lat_reg;
    period_next = period_reg;
    high_next   = high_reg;
    valid_next  = 1'b0;
    ovf_next    = ovf_reg & ~ovf_clr;
    stuck_next  = stuck_reg;

    if (!cap_en) begin
      state_next  = IDLE;
      cnt_next    = '0;
      hi_lat_next = '0;
      ovf_next    = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          cnt_next   = '0;
          state_next = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            cnt_next   = CNT_W'(1);
            state_next = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          // A fall at the limit still leaves no room for the low phase.
          if (at_limit) begin
            ovf_next   = 1'b1;
            stuck_next = s_in;
            cnt_next   = '0;
            state_next = WAIT_RISE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
            if (fall) begin
              hi_lat_next = cnt_reg;
              state_next  = MEAS_LOW;
            end
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            period_next = cnt_reg;
            high_next   = hi_lat_reg;
            valid_next  = 1'b1;
            cnt_next    = CNT_W'(1);
            state_next  = MEAS_HIGH;
          end else if (at_limit) begin
            ovf_next   = 1'b1;
            stuck_next = s_in;
            cnt_next   = '0;
            state_next = WAIT_RISE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      hi_lat_reg <= '0;
      period_reg <= '0;
      high_reg   <= '0;
      valid_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      stuck_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hi_lat_reg <= hi_lat_next;
      period_reg <= period_next;
      high_reg   <= high_next;
      valid_reg  <= valid_next;
      ovf_reg    <= ovf_next;
      stuck_reg  <= stuck_next;
    end
  end

  assign period_out  = period_reg;
  assign high_out    = high_reg;
  assign meas_valid  = valid_reg;
  assign busy        = is_measuring(state_reg);
  assign overflow    = ovf_reg;
  assign stuck_level = stuck_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (CNT_W=8 so overflow is reachable).
module tb_pwm_capture;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cap_en = 1'b0;
  logic         ovf_clr = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] period_out;
  logic [W-1:0] high_out;
  logic         meas_valid;
  logic         busy;
  logic         overflow;
  logic         stuck_level;

  int n_cmp = 0;
  int n_err = 0;
  logic [2*W-1:0] res_q[$];

  pwm_capture #(.CNT_W(W), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_en      (cap_en),
    .ovf_clr     (ovf_clr),
    .pwm_in      (pwm_in),
    .period_out  (period_out),
    .high_out    (high_out),
    .meas_valid  (meas_valid),
    .busy        (busy),
    .overflow    (overflow),
    .stuck_level (stuck_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      res_q.push_back({period_out, high_out});
      $display("t=%0t meas period=%0d high=%0d", $time, period_out, high_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seg(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) tick();
  endtask

  task automatic drive_cycles(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      seg(1'b1, hi);
      seg(1'b0, lo);
    end
  endtask

  task automatic restart();
    cap_en = 1'b0;
    pwm_in = 1'b0;
    repeat (3) tick();
    cap_en = 1'b1;
    repeat (4) tick();
    res_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++; if (period_out !== 8'd0) begin n_err++; $display("FAIL reset_period: got %0d want 0", period_out); end
    n_cmp++; if (high_out !== 8'd0) begin n_err++; $display("FAIL reset_high: got %0d want 0", high_out); end
    n_cmp++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", meas_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_cmp++; if (stuck_level !== 1'b0) begin n_err++; $display("FAIL reset_stuck: got %b want 0", stuck_level); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_steady();
    restart();
    drive_cycles(3, 5, 6);
    repeat (2) tick();
    n_cmp++; if (res_q.size() !== 5) begin n_err++; $display("FAIL steady_count: got %0d want 5", res_q.size()); end
    for (int i = 0; i < res_q.size(); i++) begin
      n_cmp++;
      if (res_q[i] !== {8'd8, 8'd3}) begin
        n_err++; $display("FAIL steady_result[%0d]: got period=%0d high=%0d want 8/3", i, res_q[i][15:8], res_q[i][7:0]);
      end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL steady_ovf: got %b want 0", overflow); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL steady_busy: got %b want 1", busy); end
  endtask

  task automatic test_latency();
    restart();
    seg(1'b1, 3);
    seg(1'b0, 5);
    pwm_in = 1'b1;
    tick();
    n_cmp++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL lat_edge1: got %b want 0", meas_valid); end
    tick();
    n_cmp++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL lat_edge2: got %b want 0", meas_valid); end
    tick();
    n_cmp++; if (meas_valid !== 1'b1) begin n_err++; $display("FAIL lat_edge3: got %b want 1", meas_valid); end
    n_cmp++; if ({period_out, high_out} !== {8'd8, 8'd3}) begin n_err++; $display("FAIL lat_result: got %0d/%0d want 8/3", period_out, high_out); end
    tick();
    n_cmp++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL lat_pulse_width: got %b want 0", meas_valid); end
    seg(1'b0, 4);
  endtask

  task automatic test_loopback();
    restart();
    drive_cycles(4, 6, 4);
    repeat (2) tick();
    n_cmp++; if (res_q.size() !== 3) begin n_err++; $display("FAIL loop_count: got %0d want 3", res_q.size()); end
    for (int i = 0; i < res_q.size(); i++) begin
      n_cmp++;
      if (res_q[i] !== {8'd10, 8'd4}) begin
        n_err++; $display("FAIL loop_result[%0d]: got period=%0d high=%0d want 10/4", i, res_q[i][15:8], res_q[i][7:0]);
      end
    end
  endtask

  task automatic test_overflow_low();
    restart();
    seg(1'b1, 4);
    seg(1'b0, 300);
    n_cmp++; if (res_q.size() !== 0) begin n_err++; $display("FAIL ovl_no_valid: got %0d results want 0", res_q.size()); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovl_flag: got %b want 1", overflow); end
    n_cmp++; if (stuck_level !== 1'b0) begin n_err++; $display("FAIL ovl_stuck: got %b want 0", stuck_level); end
    n_cmp++; if ({period_out, high_out} !== {8'd10, 8'd4}) begin n_err++; $display("FAIL ovl_keep: got %0d/%0d want 10/4", period_out, high_out); end
  endtask

  task automatic test_overflow_high();
    restart();
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovh_en_clear: got %b want 0", overflow); end
    seg(1'b1, 200);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovh_early: got %b want 0", overflow); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ovh_busy: got %b want 1", busy); end
    seg(1'b1, 100);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovh_flag: got %b want 1", overflow); end
    n_cmp++; if (stuck_level !== 1'b1) begin n_err++; $display("FAIL ovh_stuck: got %b want 1", stuck_level); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovh_wait_rise: got busy=%b want 0", busy); end
    n_cmp++; if (res_q.size() !== 0) begin n_err++; $display("FAIL ovh_no_valid: got %0d results want 0", res_q.size()); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    repeat (3) tick();
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovh_clr: got %b want 0", overflow); end
    n_cmp++; if (stuck_level !== 1'b1) begin n_err++; $display("FAIL ovh_stuck_hold: got %b want 1", stuck_level); end
    n_cmp++; if ({period_out, high_out} !== {8'd10, 8'd4}) begin n_err++; $display("FAIL ovh_keep: got %0d/%0d want 10/4", period_out, high_out); end
  endtask

  task automatic test_disable();
    restart();
    drive_cycles(3, 5, 2);
    repeat (3) tick();
    n_cmp++; if (res_q.size() !== 1) begin n_err++; $display("FAIL dis_pre_count: got %0d want 1", res_q.size()); end
    cap_en = 1'b0;
    drive_cycles(2, 3, 3);
    n_cmp++; if (res_q.size() !== 1) begin n_err++; $display("FAIL dis_no_valid: got %0d want 1", res_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dis_busy: got %b want 0", busy); end
    n_cmp++; if ({period_out, high_out} !== {8'd8, 8'd3}) begin n_err++; $display("FAIL dis_keep: got %0d/%0d want 8/3", period_out, high_out); end
    cap_en = 1'b1;
    repeat (3) tick();
    drive_cycles(4, 4, 1);
    n_cmp++; if (res_q.size() !== 1) begin n_err++; $display("FAIL dis_one_rise: got %0d want 1", res_q.size()); end
    n_cmp++; if (period_out !== 8'd8) begin n_err++; $display("FAIL dis_period_hold: got %0d want 8", period_out); end
    seg(1'b1, 6);
    n_cmp++; if (res_q.size() !== 2) begin n_err++; $display("FAIL dis_two_rise: got %0d want 2", res_q.size()); end
    else begin
      n_cmp++; if (res_q[1] !== {8'd8, 8'd4}) begin n_err++; $display("FAIL dis_result: got %0d/%0d want 8/4", res_q[1][15:8], res_q[1][7:0]); end
    end
  endtask

  task automatic test_reset_mid();
    restart();
    seg(1'b1, 7);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    pwm_in = 1'b0;
    #1;
    n_cmp++; if ({period_out, high_out} !== 16'd0) begin n_err++; $display("FAIL rmid_results: got %0d/%0d want 0/0", period_out, high_out); end
    n_cmp++; if ({busy, meas_valid, overflow, stuck_level} !== 4'b0000) begin n_err++; $display("FAIL rmid_flags: got %b want 0000", {busy, meas_valid, overflow, stuck_level}); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    res_q.delete();
    drive_cycles(3, 5, 3);
    repeat (2) tick();
    n_cmp++; if (res_q.size() !== 2) begin n_err++; $display("FAIL rmid_count: got %0d want 2", res_q.size()); end
    for (int i = 0; i < res_q.size(); i++) begin
      n_cmp++;
      if (res_q[i] !== {8'd8, 8'd3}) begin
        n_err++; $display("FAIL rmid_result[%0d]: got %0d/%0d want 8/3", i, res_q[i][15:8], res_q[i][7:0]);
      end
    end
  endtask

  task automatic test_filter();
    logic [2*W-1:0] exp_r[3];
    exp_r[0] = {8'd12, 8'd4};
    exp_r[1] = {8'd12, 8'd4};
    exp_r[2] = {8'd9, 8'd3};
    restart();
    seg(1'b1, 4); seg(1'b0, 3); seg(1'b1, 2); seg(1'b0, 3);
    seg(1'b1, 4); seg(1'b0, 8);
    seg(1'b1, 3); seg(1'b0, 6);
    seg(1'b1, 10);
    n_cmp++; if (res_q.size() !== 3) begin n_err++; $display("FAIL filt_count: got %0d want 3", res_q.size()); end
    for (int i = 0; i < res_q.size() && i < 3; i++) begin
      n_cmp++;
      if (res_q[i] !== exp_r[i]) begin
        n_err++; $display("FAIL filt_result[%0d]: got %0d/%0d want %0d/%0d", i, res_q[i][15:8], res_q[i][7:0], exp_r[i][15:8], exp_r[i][7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
`ifndef PWM_CAP_FILTER_EN
    test_latency();
`endif
    test_loopback();
    test_overflow_low();
    test_overflow_high();
    test_disable();
    test_reset_mid();
`ifdef PWM_CAP_FILTER_EN
    test_filter();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
